// File: rtl/gate_array_sequencer.sv
// Self-test sequencer for an AND gate array: walks every input vector, holds each
// for a programmable settle time, samples the array and accumulates pass/fail results.
module gate_array_sequencer #(
  parameter int unsigned BLOCKS        = 4,
  parameter int unsigned WIDTH_IN      = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       Clk,
  input  logic                       Clear,
  input  logic                       Start,
  input  logic [BLOCKS-1:0]          Y_in,
  output logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Pass,
  output logic [WIDTH_IN:0]          Fail_Count,
  output logic [WIDTH_IN-1:0]        First_Fail_Vector,
  output logic [BLOCKS-1:0]          First_Fail_Mask
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [7:0]          SettleInit = 8'(SETTLE_CYCLES);
  localparam logic [WIDTH_IN-1:0] VecLast    = {WIDTH_IN{1'b1}};

  // Block b gets (v + b) mod 2^WIDTH_IN so neighbouring gates never see the same vector.
  function automatic logic [BLOCKS*WIDTH_IN-1:0] pattern(input logic [WIDTH_IN-1:0] v);
    logic [BLOCKS*WIDTH_IN-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < BLOCKS; b++) begin
      p[b*WIDTH_IN +: WIDTH_IN] = v + WIDTH_IN'(b);
    end
    return p;
  endfunction

  state_e                      state_q, state_d;
  logic [WIDTH_IN-1:0]         vec_q, vec_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [BLOCKS*WIDTH_IN-1:0]  a_q, a_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        pass_q, pass_d;
  logic [WIDTH_IN:0]           fail_cnt_q, fail_cnt_d;
  logic [WIDTH_IN-1:0]         ff_vec_q, ff_vec_d;
  logic [BLOCKS-1:0]           ff_mask_q, ff_mask_d;
  logic [BLOCKS-1:0]           expect_y;
  logic [BLOCKS-1:0]           mask;

  // State and result registers; Clear wipes everything, including partial results.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q    <= StIdle;
      vec_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_mask_q  <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_cnt_q <= fail_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_mask_q  <= ff_mask_d;
    end
  end

  // Expected AND per gate from the held vector; x/z on Y_in never matches.
  always_comb begin
    expect_y = '0;
    mask     = '0;
    for (int unsigned b = 0; b < BLOCKS; b++) begin
      expect_y[b] = &a_q[b*WIDTH_IN +: WIDTH_IN];
      mask[b]     = (Y_in[b] === expect_y[b]) ? 1'b0 : 1'b1;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (Start) state_d = StSettle;
      StSettle:       if (cnt_q == 8'd1) state_d = StSettle == StSettle ? StSample : StSample;
      StSample:       state_d = (vec_q == VecLast) ? StDone : StSettle;
      default:        state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, vector index and settle counter.
  always_comb begin
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_cnt_d = fail_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_mask_d  = ff_mask_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          vec_d      = '0;
          cnt_d      = SettleInit;
          a_d        = pattern('0);
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_cnt_d = '0;
          ff_vec_d   = '0;
          ff_mask_d  = '0;
        end
      end
      StSettle: begin
        if (cnt_q != 8'd1) cnt_d = cnt_q - 8'd1;
      end
      StSample: begin
        if (mask != '0) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) begin
            ff_vec_d  = vec_q;
            ff_mask_d = mask;
          end
        end
        if (vec_q != VecLast) begin
          vec_d = vec_q + 1'b1;
          a_d   = pattern(vec_q + 1'b1);
          cnt_d = SettleInit;
        end else begin
          a_d    = '0;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (fail_cnt_d == '0);
        end
      end
      default: ;
    endcase
  end

  assign A_2D              = a_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign Pass              = pass_q;
  assign Fail_Count        = fail_cnt_q;
  assign First_Fail_Vector = ff_vec_q;
  assign First_Fail_Mask   = ff_mask_q;

endmodule

// File: doc/gate_array_sequencer.md
Name: gate_array_sequencer

Overview:
- Self-test sequencer for a parameterised AND gate array (BLOCKS gates, WIDTH_IN inputs each).
- Drives the gate array's packed input bus through every input combination and waits a programmable settle time per vector.
- Samples the array outputs and compares them with the expected AND result, accumulating pass/fail status.
- Sits between a board-level test controller (Start/Done) and the gate array under test.

Parameters:
- BLOCKS, 4, number of gates in the array.
- WIDTH_IN, 2, inputs per gate; 2^WIDTH_IN vectors are applied.
- SETTLE_CYCLES, 2, clocks A_2D is held before sampling; legal range 1..255.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Clear  input  1  synchronous, active-high reset.
- Start  input  1  request a test run; sampled on Clk.
- Y_in  input  BLOCKS  outputs of the gate array under test.
- A_2D  output  BLOCKS*WIDTH_IN  packed gate inputs; block b occupies bits [b*WIDTH_IN +: WIDTH_IN].
- Busy  output  1  high while a run is in progress.
- Done  output  1  high from run completion until next accepted Start or Clear.
- Pass  output  1  valid while Done: 1 when no mismatch occurred.
- Fail_Count  output  WIDTH_IN+1  number of vectors with at least one mismatching gate.
- First_Fail_Vector  output  WIDTH_IN  vector index of the first failing vector.
- First_Fail_Mask  output  BLOCKS  per-gate mismatch bits of the first failing vector.

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high (Clear).
- Clear high at an edge: state IDLE and all outputs 0 (A_2D=0, Busy=0, Done=0, Pass=0, counters and capture registers 0).
  - Clear overrides Start and aborts a run mid-operation.
  - No partial results are retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with Start=1 at an edge:
  - go to SETTLE with vector v=0 and settle counter = SETTLE_CYCLES.
  - Busy=1, Done=0, Pass=0; Fail_Count and first-fail registers cleared.
  - A_2D = pattern(0).
- pattern(v): block b receives (v + b) mod 2^WIDTH_IN, with WIDTH_IN-bit wrap. Adjacent gates therefore never share a vector, which exposes cross-wired inputs.
- Expected Y[b] = AND-reduce of block b's field.
- SETTLE:
  - Decrement the counter each edge.
  - Move to SAMPLE on the edge where the counter reaches 1.
  - A_2D is held constant, so SETTLE lasts exactly SETTLE_CYCLES clocks.
- SAMPLE (one clock): at the leaving edge, compute mask = Y_in XOR expected.
  - Any Y_in bit not 0/1 (x/z) counts as a mismatch; compare with case-equality.
  - If mask != 0: Fail_Count increments. If it is the first failure of the run, capture First_Fail_Vector=v and First_Fail_Mask=mask.
  - If v < 2^WIDTH_IN-1: v increments, A_2D = pattern(v+1), counter reloads, go to SETTLE.
  - Else go to DONE.
- DONE: Busy=0, Done=1, Pass = (Fail_Count==0). A_2D returns to 0. Results hold.
- Run length from the accepting edge to Done=1 is exactly 2^WIDTH_IN*(SETTLE_CYCLES+1) clocks.
- Start while Busy is ignored; no queuing.
- Fail_Count cannot overflow: its maximum is 2^WIDTH_IN, which fits in WIDTH_IN+1 bits.
- All outputs are registered. There is no combinational path from Y_in or Start to any output.

Test Plan (BLOCKS=4, WIDTH_IN=2, SETTLE_CYCLES=2, Clk period 10; Y_in wired to a gate-array model with DELAY_RISE=5, DELAY_FALL=3):
- Reset: Clear=1 for 2 clocks with random Start -> A_2D=8'h00, Busy=0, Done=0, Pass=0, Fail_Count=0.
- Start one clock after reset -> vector sequence:
  - v0: A_2D=8'hE4 held 3 clocks, expected Y 4'b1000.
  - v1: A_2D=8'h39, expected Y 4'b0100.
  - v2: A_2D=8'h4E, expected Y 4'b0010.
  - v3: A_2D=8'h93, expected Y 4'b0001.
  - Done=1 exactly 12 clocks after the accepting edge; Pass=1, Fail_Count=0.
- Fault: force Y_in[2]=0 -> Pass=0, Fail_Count=1, First_Fail_Vector=2'd1, First_Fail_Mask=4'b0100.
- X inputs: Y_in driven 4'bxxxx throughout -> Fail_Count=3'd4, First_Fail_Vector=0, First_Fail_Mask=4'b1111.
- Start pulsed during Busy -> ignored and run length unchanged. Start in DONE -> results cleared and a new run begins next edge.
- Clear asserted during v2 SETTLE -> next edge: IDLE, A_2D=0, Busy=0, Done=0. A later Start produces a full clean run with Pass=1.
